// File: rtl/interval_arbiter.sv
// Round-robin arbiter sharing one interval counter among NUM_REQ requesters.
// Optional INTERVAL_ARBITER_ABORT_EN: dropping req[winner] during RUN aborts the interval.
module interval_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [WIDTH-1:0]         cnt
);

  // state | meaning: IDLE = arbitrate, RUN = count enabled ticks, DONE = one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      winner_q;
  logic [WIDTH-1:0]   limit_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               busy_q;

  logic [WIDTH-1:0]   len_arr [NUM_REQ];
  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      ptr_d;
  logic               abort;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
    assign len_arr[i] = req_len[i*WIDTH +: WIDTH];
  end

  // Walk from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    idx        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      idx = sum[IW-1:0];
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  always_comb begin
    if (winner_q == IW'(NUM_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = winner_q + 1'b1;
    end
  end

`ifdef INTERVAL_ARBITER_ABORT_EN
  assign abort = ~req[winner_q];
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      limit_q  <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            winner_q <= pick_idx;
            limit_q  <= len_arr[pick_idx];
            cnt_q    <= '0;
            grant_q  <= NUM_REQ'(1) << pick_idx;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= S_IDLE;
          end else if (enable) begin
            if (cnt_q == limit_q) begin
              grant_q <= '0;
              done_q  <= grant_q;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= S_IDLE;
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign cnt   = cnt_q;

endmodule

// File: doc/interval_arbiter.md
# interval_arbiter

Shares one free-running interval counter among NUM_REQ requesters. Each requester asks for a timed interval of programmable length. A round-robin arbiter grants the counter to one requester at a time, runs that requester's interval on qualified ticks, and returns a one-cycle done pulse to the winner. The block sits between requesting control FSMs (pacing, timeouts, delays) and a single counter datapath, so each requester does not need its own counter.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- WIDTH, 8: counter and length width.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  tick qualifier; the counter advances only on cycles with enable=1.
- req  in  NUM_REQ  per-requester interval request, level.
- req_len  in  NUM_REQ*WIDTH  interval limits; requester i uses bits [i*WIDTH +: WIDTH].
- grant  out  NUM_REQ  one-hot owner of the counter, registered; all zero when idle.
- done  out  NUM_REQ  one-cycle completion pulse to the owner, registered.
- busy  out  1  high in states RUN and DONE.
- cnt  out  WIDTH  current count of the running interval.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is high, select a winner round-robin. Search starts at index ptr and wraps modulo NUM_REQ.
  - Latch req_len[winner] into the limit register, clear cnt, set grant to the winner's one-hot, then go to RUN.
  - If no req bit is high, stay in IDLE.
- RUN:
  - On enable=1 with cnt<limit: cnt <= cnt+1.
  - On enable=1 with cnt==limit: go to DONE.
  - On enable=0: hold cnt and state.
  - A limit of L takes exactly L+1 enabled ticks. L=0 completes on the first enabled tick.
- DONE:
  - Lasts one cycle. done[winner]=1, grant=0, cnt is held at limit.
  - ptr <= (winner+1) mod NUM_REQ.
  - Next state is IDLE.
- req and req_len are sampled only in IDLE. Changes during RUN have no effect, except as described under Configuration.
- A requester that keeps req high after its done pulse re-enters arbitration in IDLE. Because its priority is now lowest, the others get their turn first.
- cnt never exceeds limit. No wrap-around is possible because arithmetic stays within WIDTH bits.

## Timing
- Reset values: state=IDLE, grant=0, done=0, busy=0, cnt=0, limit=0, ptr=0, so requester 0 has first priority.
- Reset is synchronous and has priority over everything, including reset mid-RUN. In the cycle after reset, all outputs hold their reset values and any pending done pulse is dropped.
- Latency:
  - req is high in IDLE at edge t; grant and busy are high after edge t+1.
  - For a limit of L with enable held at 1, done is high in cycle t+L+2. grant falls in that same cycle.
  - The earliest next grant is at t+L+3, one IDLE cycle later.
- Back-to-back throughput is one interval per L+3 cycles when enable is held at 1.
- In the DONE cycle, done and grant never overlap for the same requester.
- If several req bits rise in the same cycle, only ptr decides the winner. Requester index matters only through the ptr search order.

## Configuration
- INTERVAL_ARBITER_ABORT_EN defined:
  - In RUN, if req[winner] is low, the interval aborts and the state goes straight to IDLE.
  - No done pulse is issued, grant clears after the next edge, and ptr advances past the winner.
  - Abort has priority over completion in the same cycle.
- INTERVAL_ARBITER_ABORT_EN undefined:
  - req[winner] is ignored during RUN, and the interval always runs to completion with a done pulse.

## Test plan
- Single request: req=4'b0010, req_len[1]=3, enable=1 from t0.
  - Required: grant=4'b0010 at t0+1, cnt steps 0,1,2,3.
  - Required: done=4'b0010 at t0+5, busy low at t0+6.
- Round-robin: req=4'b1111 held, all lengths 0.
  - Required: grants go 0,1,2,3,0, each granted for 1 cycle followed by DONE then IDLE.
  - Required: a 3-cycle spacing between done pulses.
- Enable gating: req[2]=1, len=2, enable toggled 1,0,1,0,1.
  - Required: cnt holds on enable=0 cycles, and done[2] follows the third enabled tick.
- Zero length with stalled ticks: len=0, enable=0 for 5 cycles, then 1.
  - Required: grant is held throughout, and done fires the cycle after the first enable=1.
- Reset mid-RUN: assert reset at cnt=2 of len=5.
  - Required: next cycle grant=0, busy=0, cnt=0, and no done pulse.
  - Required: after reset, req=4'b1000 is granted first.
- Abort (macro defined): drop req[0] at cnt=1 of len=4.
  - Required: no done pulse, IDLE on the next edge.
  - Required: with req[0] and req[1] re-raised together, requester 1 wins.
  - With the macro undefined, the same stimulus yields done[0] after 5 ticks.
